fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
// - Shares the write port of one dual-clock FIFO between N_REQ packet sources in the in_clk_i domain.
// - Performs round-robin arbitration at packet granularity and holds the grant until the beat marked last.
// - Sits between the producers and the FIFO in_valid/in_ready/in_value port.
// PARAMETERS
// - N_REQ        4   number of requesters, must be >= 2
// - VALUE_WIDTH  8   data width; matches the FIFO VALUE_WIDTH
// - MAX_BURST    16  beat limit per grant; used only when FIFO_ARB_BURST_LIMIT_EN is defined
// PORTS
// - in_clk_i      in   1                  clock
// - reset_n_i     in   1                  reset, asynchronous, active-low
// - req_valid_i   in   N_REQ              per-requester beat valid
// - req_last_i    in   N_REQ              per-requester last beat of packet
// - req_value_i   in   N_REQ*VALUE_WIDTH  per-requester data, packed [N_REQ-1:0][VALUE_WIDTH-1:0]
// - req_ready_o   out  N_REQ              per-requester ready
// - fifo_valid_o  out  1                  to FIFO in_valid_i
// - fifo_ready_i  in   1                  from FIFO in_ready_o
// - fifo_value_o  out  VALUE_WIDTH        to FIFO in_value_i
// - grant_id_o    out  $clog2(N_REQ)      current or last granted requester
// - busy_o        out  1                  1 while in LOCKED
// BEHAVIOUR
// - Reset values: state IDLE, rr_ptr 0, grant_id_o 0, busy_o 0, req_ready_o 0, fifo_valid_o 0, fifo_value_o 0.
// - States: IDLE, LOCKED.
// - IDLE, when any req_valid_i is set: pick the first valid index at or after rr_ptr (cyclic).
//   - Next edge: register the winner into grant_id_o and go to LOCKED.
//   - No beat is transferred in IDLE, so each packet costs exactly 1 bubble cycle.
// - LOCKED: combinational pass-through of the granted requester g:
//   - fifo_valid_o = req_valid_i[g]
//   - fifo_value_o = req_value_i[g]
//   - req_ready_o[g] = fifo_ready_i; all other req_ready_o bits are 0
// - Beat accepted when fifo_valid_o & fifo_ready_i.
//   - If req_last_i[g] is set on that beat: go to IDLE and set rr_ptr = g+1 (wraps modulo N_REQ).
// - Requester g may drop valid mid-packet. The lock is held indefinitely; there is no timeout.
// - FIFO full (fifo_ready_i = 0): stall with no state change. Data and last from g must stay stable.
// - Requests raised while LOCKED are only considered on return to IDLE.
// - Single-beat packet (valid & last together): IDLE -> LOCKED -> 1 beat -> IDLE, 2 cycles total.
// - In IDLE, fifo_value_o is 0 and grant_id_o holds the previous grant.
// - Reset asserted mid-packet: immediate return to reset values. The partial packet already in the FIFO is not recalled.
// CONFIGURATION
// - FIFO_ARB_BURST_LIMIT_EN defined: a beat counter (width $clog2(MAX_BURST+1)) is cleared on grant and incremented per accepted beat.
//   - When the counter reaches MAX_BURST without last, the block releases to IDLE and advances rr_ptr = g+1.
//   - The source resumes its packet on its next grant, so packet interleaving in the FIFO is permitted.
// - FIFO_ARB_BURST_LIMIT_EN undefined: no counter and no forced release; packets are never interleaved.
// STRUCTURE
// - Package fifo_arb_pkg:
//   - typedef enum logic {IDLE, LOCKED} arb_state_t
//   - localparam function clog2-based widths for the id and the beat counter
// - Sub-module rr_pick: combinational round-robin picker.
//   - Inputs: req vector, rr_ptr. Outputs: winner index, any_req.
//   - Implemented with a doubled-vector mask.
// - The top level holds the state register, grant register, rr_ptr and the optional counter.
// TESTING
// - All 4 requesters issue 3-beat packets continuously, fifo_ready_i = 1 -> grants 0,1,2,3,0; each packet contiguous; 4 cycles per packet.
// - Req 2 only, packet values A0,A1,A2 with fifo_ready_i low on the 2nd beat for 3 cycles -> fifo_value_o holds A1, no loss or duplication, grant stays 2.
// - rr_ptr = 3 after a grant to req 2, then req 0 and req 3 request together -> req 3 wins, then req 0.
// - Reset pulse during beat 2 of a 5-beat packet -> busy_o = 0 and req_ready_o = 0 immediately; the next grant restarts from req 0.
// - FIFO_ARB_BURST_LIMIT_EN, MAX_BURST = 4, req 0 sends 10 beats with req 1 pending -> 4 beats from req 0, then req 1's packet, then req 0 resumes at beat 5.
// - Single-beat packets from req 1 every cycle -> one beat every 2 cycles; busy_o toggles 1/0.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Used by fifo_wr_arbiter and rr_pick.
package fifo_arb_pkg;

    // Arbiter state: waiting for a request, or holding a packet grant
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Width of a requester index; never narrower than one bit
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of a beat counter that must be able to hold the value m
    function automatic int cnt_w(input int m);
        return (m > 1) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after rr_ptr.
// The request vector is doubled so the cyclic search becomes a linear one.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int IW = id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [IW-1:0]    winner,
    output logic             any_req
);

    logic [2*N_REQ-1:0] dbl;
    logic [IW:0]        pos;

    assign dbl     = {req, req};
    assign any_req = |req;

    // Lowest set bit of the doubled vector inside [rr_ptr, rr_ptr+N_REQ)
    always_comb begin
        pos = '0;
        for (int j = 2*N_REQ-1; j >= 0; j--) begin
            if (dbl[j] && (j >= int'(rr_ptr)) &&
                (j < int'(rr_ptr) + N_REQ)) begin
                pos = (IW+1)'(j);
            end
        end
    end

    // Fold the doubled-vector position back into the requester range
    always_comb begin
        if (pos >= (IW+1)'(N_REQ)) begin
            winner = IW'(pos - (IW+1)'(N_REQ));
        end else begin
            winner = pos[IW-1:0];
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Packet-granular round-robin arbiter for one FIFO write port.
// Optional per-grant beat cap is enabled by FIFO_ARB_BURST_LIMIT_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int VALUE_WIDTH = 8,
    parameter int MAX_BURST   = 16
) (
    input  logic                         in_clk_i,
    input  logic                         reset_n_i,
    input  logic [N_REQ-1:0]             req_valid_i,
    input  logic [N_REQ-1:0]             req_last_i,
    input  logic [N_REQ*VALUE_WIDTH-1:0] req_value_i,
    output logic [N_REQ-1:0]             req_ready_o,
    output logic                         fifo_valid_o,
    input  logic                         fifo_ready_i,
    output logic [VALUE_WIDTH-1:0]       fifo_value_o,
    output logic [id_w(N_REQ)-1:0]       grant_id_o,
    output logic                         busy_o
);

    localparam int IW = id_w(N_REQ);

    if (N_REQ < 2 || MAX_BURST < 1) begin : g_bad_cfg
        $error("fifo_wr_arbiter: N_REQ must be >= 2, MAX_BURST >= 1");
    end

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_q;
    logic          busy_q;
    logic [IW-1:0] winner;
    logic [IW-1:0] next_ptr;
    logic          any_req;
    logic          locked;
    logic          g_valid;
    logic          g_last;
    logic          beat;
    logic          release_pkt;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .req     (req_valid_i),
        .rr_ptr  (rr_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    assign locked  = (state == LOCKED);
    assign g_valid = req_valid_i[grant_q];
    assign g_last  = req_last_i[grant_q];
    assign beat    = locked & g_valid & fifo_ready_i;

    assign next_ptr = (grant_q == IW'(N_REQ - 1)) ?
                      '0 : grant_q + IW'(1);

`ifdef FIFO_ARB_BURST_LIMIT_EN
    localparam int CW = cnt_w(MAX_BURST);

    logic [CW-1:0] beat_cnt;
    logic          cap_hit;

    // Beat being accepted now is the last one allowed for this grant
    assign cap_hit     = (beat_cnt == CW'(MAX_BURST - 1));
    assign release_pkt = beat & (g_last | cap_hit);

    // Beats accepted under the current grant, cleared when a grant is won
    always_ff @(posedge in_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            beat_cnt <= '0;
        end else if (!locked && any_req) begin
            beat_cnt <= '0;
        end else if (beat) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end
`else
    assign release_pkt = beat & g_last;
`endif

    // Grant FSM: win in IDLE, hold the lock until the packet is released
    always_ff @(posedge in_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= winner;
                        state   <= LOCKED;
                        busy_q  <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (release_pkt) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
            endcase
        end
    end

    // Pass-through of the granted requester while locked, quiet otherwise
    always_comb begin
        fifo_valid_o = locked & g_valid;
        fifo_value_o = '0;
        req_ready_o  = '0;
        if (locked) begin
            fifo_value_o =
                req_value_i[grant_q*VALUE_WIDTH +: VALUE_WIDTH];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (locked && (grant_q == IW'(i))) begin
                req_ready_o[i] = fifo_ready_i;
            end
        end
    end

    assign grant_id_o = grant_q;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (4 requesters, 8-bit data).
// Burst-cap case runs only when FIFO_ARB_BURST_LIMIT_EN is defined.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_last;
    logic [31:0] req_value;
    logic [3:0]  req_ready;
    logic        fifo_valid;
    logic        fifo_ready;
    logic [7:0]  fifo_value;
    logic [1:0]  grant_id;
    logic        busy;

    int n_chk;
    int n_bad;

    fifo_wr_arbiter #(
        .N_REQ       (4),
        .VALUE_WIDTH (8),
        .MAX_BURST   (4)
    ) dut (
        .in_clk_i     (clk),
        .reset_n_i    (rst_n),
        .req_valid_i  (req_valid),
        .req_last_i   (req_last),
        .req_value_i  (req_value),
        .req_ready_o  (req_ready),
        .fifo_valid_o (fifo_valid),
        .fifo_ready_i (fifo_ready),
        .fifo_value_o (fifo_value),
        .grant_id_o   (grant_id),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    int beat[4];
    int g;
    int bb[7]   = '{0, 0, 1, 1, 1, 1, 2};
    int rdy[7]  = '{1, 1, 0, 0, 0, 1, 1};
    int ev[7]   = '{0, 1, 1, 1, 1, 1, 1};
    int eval[7] = '{0, 'hA0, 'hA1, 'hA1, 'hA1, 'hA1, 'hA2};
    int er2[7]  = '{0, 1, 0, 0, 0, 1, 1};
    int cv[5]   = '{0, 1, 0, 1, 0};
    int cg[5]   = '{0, 3, 0, 0, 0};
    int cval[5] = '{0, 'h3C, 0, 'h0C, 0};
    bit p0;
    bit p3;

    initial begin
        n_chk      = 0;
        n_bad      = 0;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_last   = '0;
        req_value  = '0;
        fifo_ready = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_busy",  busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_fval",  fifo_valid, 0);
        chk("rst_value", fifo_value, 0);
        chk("rst_grant", grant_id, 0);
        next_cyc();
        rst_n = 1'b1;

        // all four sources, 3-beat packets back to back
        for (int i = 0; i < 4; i++) beat[i] = 0;
        for (int c = 0; c < 20; c++) begin
            req_valid  = 4'hF;
            fifo_ready = 1'b1;
            for (int i = 0; i < 4; i++) begin
                req_last[i] = (beat[i] == 2);
                req_value[i*8 +: 8] = 8'(16*i + beat[i]);
            end
            @(negedge clk);
            if (c % 4 == 0) begin
                chk("a_bubble", fifo_valid, 0);
                chk("a_idle",   busy, 0);
            end else begin
                g = (c / 4) % 4;
                chk("a_valid", fifo_valid, 1);
                chk("a_grant", grant_id, g);
                chk("a_value", fifo_value, 16*g + (c % 4) - 1);
                chk("a_ready", req_ready, 1 << g);
            end
            for (int i = 0; i < 4; i++)
                if (req_ready[i]) beat[i] = (beat[i] + 1) % 3;
            next_cyc();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        chk("a_end_busy",  busy, 0);
        chk("a_end_grant", grant_id, 0);
        chk("a_end_value", fifo_value, 0);
        next_cyc();

        // req 2 only, FIFO stalls on the second beat for 3 cycles
        for (int c = 0; c < 7; c++) begin
            req_valid = 4'b0100;
            req_last  = {1'b0, bb[c] == 2, 2'b00};
            req_value[16 +: 8] = 8'(32'hA0 + bb[c]);
            fifo_ready = rdy[c][0];
            @(negedge clk);
            chk("b_valid", fifo_valid, ev[c]);
            chk("b_value", fifo_value, eval[c]);
            chk("b_ready", req_ready, er2[c] << 2);
            if (c > 0) chk("b_grant", grant_id, 2);
            next_cyc();
        end
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        chk("b_end_busy",  busy, 0);
        chk("b_end_grant", grant_id, 2);
        next_cyc();

        // rr_ptr now 3: req 0 and req 3 together, req 3 goes first
        p0 = 1'b1;
        p3 = 1'b1;
        req_value[0 +: 8]  = 8'h0C;
        req_value[24 +: 8] = 8'h3C;
        fifo_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req_valid = {p3, 2'b00, p0};
            req_last  = 4'b1001;
            @(negedge clk);
            chk("c_valid", fifo_valid, cv[c]);
            chk("c_value", fifo_value, cval[c]);
            if (cv[c] != 0) chk("c_grant", grant_id, cg[c]);
            if (req_ready[0]) p0 = 1'b0;
            if (req_ready[3]) p3 = 1'b0;
            next_cyc();
        end

        // reset during beat 2 of a 5-beat packet from req 1
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0010;
            req_last  = '0;
            req_value[8 +: 8] = 8'(32'h30 + (c > 0 ? c - 1 : 0));
            @(negedge clk);
            if (c > 0) begin
                chk("d_grant", grant_id, 1);
                chk("d_value", fifo_value, 32'h30 + c - 1);
            end
            if (c < 2) next_cyc();
        end
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_busy",  busy, 0);
        chk("d_rst_ready", req_ready, 0);
        chk("d_rst_fval",  fifo_valid, 0);
        next_cyc();
        rst_n = 1'b1;
        req_valid = 4'b0011;
        req_last  = 4'b0011;
        req_value[0 +: 8] = 8'h0D;
        req_value[8 +: 8] = 8'h1D;
        @(negedge clk);
        chk("d_re_idle", busy, 0);
        next_cyc();
        @(negedge clk);
        chk("d_re_grant", grant_id, 0);
        chk("d_re_value", fifo_value, 8'h0D);
        next_cyc();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("d_re_bub", fifo_valid, 0);
        next_cyc();
        @(negedge clk);
        chk("d_re_g1", grant_id, 1);
        next_cyc();
        req_valid = '0;
        req_last  = '0;
        @(negedge clk);
        chk("d_end_busy", busy, 0);
        next_cyc();

        // single-beat packets from req 1 every cycle
        g = 0;
        for (int c = 0; c < 8; c++) begin
            req_valid = 4'b0010;
            req_last  = 4'b0010;
            req_value[8 +: 8] = 8'(32'h50 + g);
            @(negedge clk);
            chk("e_busy",  busy, c % 2);
            chk("e_valid", fifo_valid, c % 2);
            if (c % 2 == 1) chk("e_value", fifo_value, 32'h50 + c / 2);
            if (req_ready[1]) g++;
            next_cyc();
        end
        req_valid = '0;
        req_last  = '0;

`ifdef FIFO_ARB_BURST_LIMIT_EN
        // beat cap of 4: req 0 sends 10 beats while req 1 waits
        begin
            int b0;
            int b1;
            int fv[13] = '{0,1,1,1,1,0,1,1,0,1,1,1,1};
            int fd[13] = '{0,0,1,2,3,0,16,17,0,4,5,6,7};
            rst_n = 1'b0;
            next_cyc();
            rst_n = 1'b1;
            b0 = 0;
            b1 = 0;
            for (int c = 0; c < 13; c++) begin
                req_valid = {2'b00, b1 < 2, b0 < 10};
                req_last  = {2'b00, b1 == 1, b0 == 9};
                req_value[0 +: 8] = 8'(b0);
                req_value[8 +: 8] = 8'(16 + b1);
                @(negedge clk);
                chk("f_valid", fifo_valid, fv[c]);
                chk("f_value", fifo_value, fd[c]);
                if (req_ready[0]) b0++;
                if (req_ready[1]) b1++;
                next_cyc();
            end
            req_valid = '0;
            req_last  = '0;
        end
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
